// File: rtl/spike_rate_decoder.sv
// Spike rate decoder: counts spikes per fixed window and hands the count to a consumer via valid/ready.
// Optional inter-spike-interval output enabled by defining SPIKE_RATE_ISI_EN.
module spike_rate_decoder #(
  parameter int WINDOW_LEN = 256,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             clear,
  input  logic             spike,
  output logic [CNT_W-1:0] rate,
  output logic             rate_valid,
  input  logic             rate_ready,
  output logic             overrun,
  output logic [7:0]       isi
);

  localparam int TW = (WINDOW_LEN > 2) ? $clog2(WINDOW_LEN) : 1;
  localparam logic [TW-1:0]    TIMER_LAST = TW'(WINDOW_LEN - 1);
  localparam logic [TW-1:0]    TIMER_ONE  = TW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [TW-1:0]    timer;
  logic [TW-1:0]    timer_nxt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic [CNT_W-1:0] final_cnt;
  logic [CNT_W-1:0] rate_r;
  logic             overrun_r;
  logic             win_close;
  logic             rate_load;
  logic             overrun_set;

  // Window timer and saturating spike count; the closing cycle's spike is folded into final_cnt.
  always_comb begin
    win_close = ena && (timer == TIMER_LAST);
    final_cnt = count;
    if (spike && (count != CNT_MAX)) begin
      final_cnt = count + CNT_ONE;
    end else begin
      final_cnt = count;
    end
    timer_nxt = timer;
    count_nxt = count;
    if (win_close) begin
      timer_nxt = '0;
      count_nxt = '0;
    end else if (ena) begin
      timer_nxt = timer + TIMER_ONE;
      count_nxt = final_cnt;
    end else begin
      timer_nxt = timer;
      count_nxt = count;
    end
  end

  // Result holding FSM: a close while FULL loads only if the consumer accepts on that same edge.
  always_comb begin
    state_nxt   = state;
    rate_load   = 1'b0;
    overrun_set = 1'b0;
    case (state)
      EMPTY: begin
        if (win_close) begin
          state_nxt = FULL;
          rate_load = 1'b1;
        end else begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (win_close) begin
          state_nxt = FULL;
          if (rate_ready) begin
            rate_load = 1'b1;
          end else begin
            overrun_set = 1'b1;
          end
        end else if (rate_ready) begin
          state_nxt = EMPTY;
        end else begin
          state_nxt = FULL;
        end
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase
  end

  // State, counters and result registers with async reset and synchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      timer     <= '0;
      count     <= '0;
      rate_r    <= '0;
      overrun_r <= 1'b0;
    end else if (clear) begin
      state     <= EMPTY;
      timer     <= '0;
      count     <= '0;
      rate_r    <= '0;
      overrun_r <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      count     <= count_nxt;
      rate_r    <= rate_load ? final_cnt : rate_r;
      overrun_r <= overrun_r | overrun_set;
    end
  end

  assign rate       = rate_r;
  assign rate_valid = (state == FULL);
  assign overrun    = overrun_r;

`ifdef SPIKE_RATE_ISI_EN
  logic [7:0] isi_cnt;
  logic [7:0] isi_r;
  logic [7:0] isi_cnt_inc;

  assign isi_cnt_inc = (isi_cnt == 8'hFF) ? 8'hFF : (isi_cnt + 8'd1);

  // Inter-spike interval: a spike captures the cycles since the previous spike, counting itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      isi_cnt <= 8'd0;
      isi_r   <= 8'd0;
    end else if (clear) begin
      isi_cnt <= 8'd0;
      isi_r   <= 8'd0;
    end else if (ena && spike) begin
      isi_cnt <= 8'd0;
      isi_r   <= isi_cnt_inc;
    end else if (ena) begin
      isi_cnt <= isi_cnt_inc;
      isi_r   <= isi_r;
    end else begin
      isi_cnt <= isi_cnt;
      isi_r   <= isi_r;
    end
  end

  assign isi = isi_r;
`else
  assign isi = 8'd0;
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Self-checking bench for spike_rate_decoder: directed scenarios plus random traffic against a reference model.
// Expected isi follows SPIKE_RATE_ISI_EN.
module tb_spike_rate_decoder;

  localparam int WL   = 16;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;
`ifdef SPIKE_RATE_ISI_EN
  localparam bit ISI_ON = 1'b1;
`else
  localparam bit ISI_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ena = 1'b0;
  logic          clear = 1'b0;
  logic          spike = 1'b0;
  logic          rate_ready = 1'b0;
  logic [CW-1:0] rate;
  logic          rate_valid;
  logic          overrun;
  logic [7:0]    isi;

  int checks = 0;
  int failures = 0;

  // Reference state kept as plain integers.
  int m_timer, m_count, m_rate, m_isi_cnt, m_isi;
  bit m_valid, m_overrun;

  spike_rate_decoder #(.WINDOW_LEN(WL), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .ena(ena), .clear(clear), .spike(spike),
    .rate(rate), .rate_valid(rate_valid), .rate_ready(rate_ready),
    .overrun(overrun), .isi(isi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_timer = 0; m_count = 0; m_rate = 0; m_valid = 0;
    m_overrun = 0; m_isi_cnt = 0; m_isi = 0;
  endtask

  task automatic model_edge(input bit e, input bit s, input bit r, input bit c);
    int fin;
    if (c) begin
      model_reset();
    end else if (e) begin
      fin = m_count + int'(s);
      if (fin > CMAX) fin = CMAX;
      if (s) begin
        m_isi = (m_isi_cnt + 1 > 255) ? 255 : m_isi_cnt + 1;
        m_isi_cnt = 0;
      end else begin
        m_isi_cnt = (m_isi_cnt + 1 > 255) ? 255 : m_isi_cnt + 1;
      end
      if (m_timer == WL - 1) begin
        m_timer = 0;
        m_count = 0;
        if (!m_valid || r) begin
          m_rate = fin;
          m_valid = 1;
        end else begin
          m_overrun = 1;
        end
      end else begin
        m_timer++;
        m_count = fin;
        if (m_valid && r) m_valid = 0;
      end
    end else if (m_valid && r) begin
      m_valid = 0;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".rate"}, int'(rate), m_rate);
    chk({tag, ".rate_valid"}, int'(rate_valid), int'(m_valid));
    chk({tag, ".overrun"}, int'(overrun), int'(m_overrun));
    chk({tag, ".isi"}, int'(isi), ISI_ON ? m_isi : 0);
  endtask

  task automatic step(input bit e, input bit s, input bit r, input bit c, input string tag);
    ena = e; spike = s; rate_ready = r; clear = c;
    @(posedge clk);
    model_edge(e, s, r, c);
    #1;
    check_model(tag);
  endtask

  initial begin
    model_reset();
    #1;
    chk("reset.rate", int'(rate), 0);
    chk("reset.rate_valid", int'(rate_valid), 0);
    chk("reset.overrun", int'(overrun), 0);
    chk("reset.isi", int'(isi), 0);
    #12 rst = 1'b0;

    // Spike every 4th cycle, consumer always ready.
    for (int i = 0; i < WL; i++) step(1'b1, (i % 4) == 0, 1'b1, 1'b0, "every4");
    chk("every4.rate", int'(rate), 4);
    chk("every4.valid", int'(rate_valid), 1);
    step(1'b1, 1'b0, 1'b1, 1'b0, "every4_drop");
    chk("every4.valid_one_cycle", int'(rate_valid), 0);
    chk("every4.overrun", int'(overrun), 0);

    // Spike held for 40 cycles: saturation then partial window.
    step(1'b0, 1'b0, 1'b1, 1'b1, "clr");
    for (int i = 0; i < 3 * WL; i++) begin
      step(1'b1, i < 40, 1'b1, 1'b0, "sat");
      if (i == 15) chk("sat.win1", int'(rate), 15);
      if (i == 31) chk("sat.win2", int'(rate), 15);
      if (i == 47) chk("sat.win3", int'(rate), 8);
    end

    // Consumer stalled across two windows.
    step(1'b0, 1'b0, 1'b1, 1'b1, "clr");
    for (int i = 0; i < WL; i++) step(1'b1, i < 3, 1'b0, 1'b0, "ovr_w1");
    chk("ovr.no_overrun_yet", int'(overrun), 0);
    for (int i = 0; i < WL; i++) step(1'b1, i < 5, 1'b0, 1'b0, "ovr_w2");
    chk("ovr.rate_held", int'(rate), 3);
    chk("ovr.overrun_set", int'(overrun), 1);
    step(1'b0, 1'b0, 1'b1, 1'b0, "ovr_accept");
    chk("ovr.valid_cleared", int'(rate_valid), 0);
    chk("ovr.overrun_sticky", int'(overrun), 1);

    // ena low for 10 cycles mid-window with spike high.
    step(1'b0, 1'b0, 1'b1, 1'b1, "clr");
    for (int i = 0; i < WL + 10; i++) begin
      step(!(i >= 8 && i < 18), (i < 2) || (i >= 8 && i < 18), 1'b1, 1'b0, "ena");
      if (i == 15) chk("ena.no_early_close", int'(rate_valid), 0);
      if (i == 24) chk("ena.not_yet", int'(rate_valid), 0);
      if (i == 25) begin
        chk("ena.closed", int'(rate_valid), 1);
        chk("ena.rate", int'(rate), 2);
      end
    end

    // Asynchronous reset mid-window while a result is pending.
    step(1'b0, 1'b0, 1'b1, 1'b1, "clr");
    for (int i = 0; i < WL; i++) step(1'b1, i % 2, 1'b0, 1'b0, "arst_fill");
    chk("arst.pending", int'(rate_valid), 1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, "arst_mid");
    #3 rst = 1'b1;
    #1 model_reset();
    chk("arst.rate", int'(rate), 0);
    chk("arst.valid", int'(rate_valid), 0);
    check_model("arst");
    #2 rst = 1'b0;
    for (int i = 0; i < WL; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, "arst_win");
      if (i == 14) chk("arst.no_close", int'(rate_valid), 0);
    end
    chk("arst.close_rate", int'(rate), 15);

    // Same again using the synchronous clear.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, "sclr_mid");
    step(1'b1, 1'b1, 1'b0, 1'b1, "sclr");
    chk("sclr.valid", int'(rate_valid), 0);
    chk("sclr.rate", int'(rate), 0);
    for (int i = 0; i < WL; i++) begin
      step(1'b1, i < 6, 1'b1, 1'b0, "sclr_win");
      if (i == 14) chk("sclr.no_close", int'(rate_valid), 0);
    end
    chk("sclr.close_rate", int'(rate), 6);

    // Inter-spike interval: spikes at cycles 0, 1 and 7.
    step(1'b0, 1'b0, 1'b1, 1'b1, "clr");
    for (int i = 0; i < 8; i++) begin
      step(1'b1, (i == 0) || (i == 1) || (i == 7), 1'b1, 1'b0, "isi");
      if (i == 1) chk("isi.back_to_back", int'(isi), ISI_ON ? 1 : 0);
      if (i == 7) chk("isi.gap", int'(isi), ISI_ON ? 6 : 0);
    end

    // Random traffic against the reference model.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) == 0, $urandom_range(0, 299) == 0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
